// File: rtl/neuai_led_pkg.sv
// Shared constants for the LED breathing controller: mode codes, LED-off pattern, default timing.
package neuai_led_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ALL   = 2'd1;
   localparam logic [1:0] MODE_CHASE = 2'd2;
   localparam logic [1:0] MODE_ALT   = 2'd3;

   localparam logic [3:0] LED_OFF = 4'b1111;

   localparam int unsigned TICK_DIV_DEF        = 50;
   localparam int unsigned PWM_STEPS_DEF       = 1000;
   localparam int unsigned CNT_W_DEF           = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

   typedef enum logic {DirUp, DirDown} dir_e;

endpackage

// File: rtl/neuai_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability counter and one-cycle pulse on a debounced press
// (1->0). The raw key is active-low and idles high.
module neuai_key_debounce #(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_ni,
   output logic press_o
);

   localparam int unsigned CntW = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic [1:0]      sync_q, sync_d;
   logic            stable_q, stable_d;
   logic            press_q, press_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d   = {sync_q[0], key_ni};
      stable_d = stable_q;
      cnt_d    = '0;
      // Any sample that agrees with the debounced level restarts the count.
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CntLast) begin
            stable_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = stable_q & ~stable_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= 2'b11;
         stable_q <= 1'b1;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/neuai_led_breath_ctrl.sv
// Four-LED breathing controller: shared duty ramp + PWM compare routed by a key-selected mode.
// Define LED_GAMMA_EN to square-law shape the compare value (w_duty stays linear).
module neuai_led_breath_ctrl
   import neuai_led_pkg::*;
#(
   parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
   parameter int unsigned PWM_STEPS       = PWM_STEPS_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic             w_key_mode,
   input  logic             w_pause,
   output logic [3:0]       w_led,
   output logic [1:0]       w_mode,
   output logic [CNT_W-1:0] w_duty,
   output logic             w_period_done
);

   localparam int unsigned      PresW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(PWM_STEPS - 1);

   logic [PresW-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   dir_e             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       active_q, active_d;
   logic [3:0]       led_q, led_d;
   logic [CNT_W-1:0] cmp, cmp_c;
   logic             tick, period_done, press, on, on_c;

   function automatic logic [CNT_W-1:0] shape(input logic [CNT_W-1:0] d);
`ifdef LED_GAMMA_EN
      logic [2*CNT_W-1:0] prod;
      prod = {{CNT_W{1'b0}}, d} * {{CNT_W{1'b0}}, d};
      return prod[2*CNT_W-1:CNT_W];
`else
      return d;
`endif
   endfunction

   neuai_key_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk_i  (w_clk),
      .rst_i  (w_rst),
      .key_ni (w_key_mode),
      .press_o(press)
   );

   always_comb begin
      tick        = (presc_q == PresMax);
      presc_d     = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d   = pwm_cnt_q;
      if (tick) begin
         pwm_cnt_d = (pwm_cnt_q == CntMax) ? '0 : pwm_cnt_q + 1'b1;
      end
      period_done = tick && (pwm_cnt_q == CntMax);
   end

   // Ramp sequencer; a press outranks the period-end update in the same cycle.
   always_comb begin
      mode_d   = mode_q;
      duty_d   = duty_q;
      dir_d    = dir_q;
      active_d = active_q;
      if (press) begin
         mode_d   = mode_q + 2'd1;
         duty_d   = '0;
         dir_d    = DirUp;
         active_d = '0;
      end else if (period_done && !w_pause) begin
         unique case (dir_q)
            DirUp: begin
               if (duty_q < CntMax) begin
                  duty_d = duty_q + 1'b1;
               end else begin
                  dir_d  = DirDown;
                  duty_d = CntMax - 1'b1;
               end
            end
            DirDown: begin
               if (duty_q != '0) begin
                  duty_d = duty_q - 1'b1;
               end else begin
                  dir_d    = DirUp;
                  duty_d   = CNT_W'(1);
                  active_d = active_q + 2'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      cmp   = shape(duty_q);
      cmp_c = shape(CntMax - duty_q);
      on    = (pwm_cnt_q < cmp);
      on_c  = (pwm_cnt_q < cmp_c);
      led_d = LED_OFF;
      unique case (mode_q)
         MODE_ALL:   led_d = {4{~on}};
         MODE_CHASE: led_d[active_q] = ~on;
         MODE_ALT:   led_d = {~on_c, ~on, ~on_c, ~on};
         default:    led_d = LED_OFF;
      endcase
   end

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         dir_q     <= DirUp;
         mode_q    <= MODE_OFF;
         active_q  <= '0;
         led_q     <= LED_OFF;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         dir_q     <= dir_d;
         mode_q    <= mode_d;
         active_q  <= active_d;
         led_q     <= led_d;
      end
   end

   assign w_led         = led_q;
   assign w_mode        = mode_q;
   assign w_duty        = duty_q;
   assign w_period_done = period_done;

endmodule

// File: tb/tb_neuai_led_breath_ctrl.sv
// Self-checking bench for neuai_led_breath_ctrl with TICK_DIV=2, PWM_STEPS=8, CNT_W=3,
// DEBOUNCE_CYCLES=4 (16-clock PWM period).
module tb_neuai_led_breath_ctrl;

   logic       w_clk;
   logic       w_rst;
   logic       w_key_mode;
   logic       w_pause;
   logic [3:0] w_led;
   logic [1:0] w_mode;
   logic [2:0] w_duty;
   logic       w_period_done;

   neuai_led_breath_ctrl #(
      .TICK_DIV       (2),
      .PWM_STEPS      (8),
      .CNT_W          (3),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .w_clk        (w_clk),
      .w_rst        (w_rst),
      .w_key_mode   (w_key_mode),
      .w_pause      (w_pause),
      .w_led        (w_led),
      .w_mode       (w_mode),
      .w_duty       (w_duty),
      .w_period_done(w_period_done)
   );

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   typedef struct packed {
      logic [1:0]      mode;
      logic [2:0]      duty;
      logic [3:0][4:0] low;   // clocks per period each LED is driven low
   } vec_t;

   vec_t vecs [5];
   int   checks = 0;
   int   errors = 0;
   int   exp_mode = 0;
   int   duty_q [$];
   int   mode_q [$];
   time  last_rel = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge w_clk);
      #1;
   endtask

   // Scoreboard monitor: duty after each period end, and each mode change.
   initial begin
      logic pd_prev;
      int   last_mode;
      pd_prev   = 1'b0;
      last_mode = 0;
      forever begin
         @(negedge w_clk);
         if (w_rst) begin
            pd_prev   = 1'b0;
            last_mode = 0;
         end else begin
            if (pd_prev && duty_q.size() > 0) chk("duty_after_period", w_duty, duty_q.pop_front());
            if (int'(w_mode) != last_mode) begin
               if (mode_q.size() == 0) begin
                  chk("unexpected_mode_change", w_mode, last_mode);
               end else begin
                  chk("mode_step", w_mode, mode_q.pop_front());
                  chk("duty_clear_on_press", w_duty, 0);
               end
               last_mode = w_mode;
            end
            pd_prev = w_period_done;
         end
      end
   end

   task automatic press();
      int n;
      while ($time - last_rel < 80) step();
      exp_mode = (exp_mode + 1) % 4;
      mode_q.push_back(exp_mode);
      w_key_mode = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (int'(w_mode) != exp_mode && n < 20);
      if (int'(w_mode) != exp_mode) chk("press_timeout", w_mode, exp_mode);
      w_key_mode = 1'b1;
      last_rel   = $time;
   endtask

   task automatic wait_duty(input int d);
      int   n;
      int   dp;
      logic pdp;
      n   = 0;
      dp  = -1;
      pdp = 1'b0;
      forever begin
         step();
         n++;
         if (pdp && dp == d - 1 && int'(w_duty) == d) break;
         if (n > 800) begin
            chk("wait_duty_timeout", n, 0);
            break;
         end
         pdp = w_period_done;
         dp  = w_duty;
      end
   endtask

   task automatic wait_q_empty(input string name, input int bound);
      int n;
      n = 0;
      while (duty_q.size() != 0 && n < bound) begin
         step();
         n++;
      end
      chk(name, duty_q.size(), 0);
   endtask

   // ORs the lit LEDs over n period ends; after a press the first sample still shows the old mode.
   task automatic collect(input int n_pd, input bit from_press, output logic [3:0] lit);
      int cnt;
      int guard;
      bit first;
      lit   = '0;
      cnt   = 0;
      guard = 0;
      first = from_press;
      if (!from_press) step();
      forever begin
         if (!first) lit |= ~w_led;
         first = 1'b0;
         if (w_period_done) cnt++;
         if (cnt == n_pd) break;
         if (guard > n_pd * 16 + 40) begin
            chk("collect_timeout", cnt, n_pd);
            break;
         end
         step();
         guard++;
      end
   endtask

   task automatic measure_first_pd();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!w_period_done && n < 40);
      // Release cycle is cycle 0, so the pulse lands in the 16th clock.
      chk("first_period_done_cycle", n, 15);
   endtask

   task automatic check_reset_outputs();
      chk("rst_led", w_led, 4'b1111);
      chk("rst_mode", w_mode, 0);
      chk("rst_duty", w_duty, 0);
      chk("rst_period_done", w_period_done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      logic [3:0] lit;
      logic [3:0] on_mask;
      int         low_cnt [4];
      bit         pushed;

      vecs[0] = '{mode: 2'd1, duty: 3'd3, low: {5'd6, 5'd6, 5'd6, 5'd6}};
      vecs[1] = '{mode: 2'd2, duty: 3'd3, low: {5'd0, 5'd0, 5'd0, 5'd6}};
      vecs[2] = '{mode: 2'd3, duty: 3'd5, low: {5'd4, 5'd10, 5'd4, 5'd10}};
      vecs[3] = '{mode: 2'd3, duty: 3'd2, low: {5'd10, 5'd4, 5'd10, 5'd4}};
      vecs[4] = '{mode: 2'd0, duty: 3'd4, low: {5'd0, 5'd0, 5'd0, 5'd0}};

      w_rst      = 1'b1;
      w_key_mode = 1'b1;
      w_pause    = 1'b0;
      #2;
      check_reset_outputs();
      @(negedge w_clk);
      #1;
      w_rst = 1'b0;
      measure_first_pd();

      // Short glitch: 3 low samples must not register.
      step();
      w_key_mode = 1'b0;
      repeat (3) step();
      w_key_mode = 1'b1;
      last_rel   = $time;
      repeat (12) step();
      chk("glitch_no_mode_change", w_mode, 0);

      // Held key: exactly one press; then scoreboard the mode-1 ramp.
      while ($time - last_rel < 80) step();
      exp_mode = 1;
      mode_q.push_back(1);
      w_key_mode = 1'b0;
      pushed = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (!pushed && w_mode == 2'd1) begin
            pushed = 1'b1;
            for (int d = 1; d <= 7; d++) duty_q.push_back(d);
            for (int d = 6; d >= 0; d--) duty_q.push_back(d);
            duty_q.push_back(1);
         end
      end
      chk("held_key_mode", w_mode, 1);
      chk("held_key_seen", pushed, 1);
      w_key_mode = 1'b1;
      last_rel   = $time;
      wait_q_empty("ramp_sequence_drained", 15 * 16 + 60);
      chk("held_key_single_press", w_mode, 1);

      // Per-mode PWM windows at a chosen duty.
      for (int v = 0; v < 5; v++) begin
         while (exp_mode != int'(vecs[v].mode)) press();
         wait_duty(vecs[v].duty);
         for (int b = 0; b < 4; b++) begin
            low_cnt[b] = 0;
            on_mask[b] = (vecs[v].low[b] == 5'd0);
         end
         for (int s = 0; s < 16; s++) begin
            if (s > 0) step();
            if (s == 0) chk($sformatf("led_lag_v%0d", v), w_led, 4'b1111);
            if (s == 1) chk($sformatf("led_first_on_v%0d", v), w_led, on_mask);
            for (int b = 0; b < 4; b++) if (!w_led[b]) low_cnt[b]++;
         end
         for (int b = 0; b < 4; b++) begin
            chk($sformatf("low_clocks_v%0d_led%0d", v, b), low_cnt[b], vecs[v].low[b]);
         end
      end

      // Chase: active LED rotates once per breath cycle.
      press();
      press();
      collect(15, 1'b1, lit);
      chk("chase_cycle0", lit, 4'b0001);
      collect(14, 1'b0, lit);
      chk("chase_cycle1", lit, 4'b0010);
      collect(14, 1'b0, lit);
      chk("chase_cycle2", lit, 4'b0100);
      collect(14, 1'b0, lit);
      chk("chase_cycle3", lit, 4'b1000);
      collect(14, 1'b0, lit);
      chk("chase_wrap", lit, 4'b0001);

      // Pause: ramp frozen, period ends continue, a press still lands.
      press();
      wait_duty(4);
      w_pause = 1'b1;
      duty_q.push_back(4);
      duty_q.push_back(4);
      wait_q_empty("pause_hold", 2 * 16 + 40);
      press();
      repeat (3) duty_q.push_back(0);
      wait_q_empty("pause_after_press", 3 * 16 + 40);
      chk("pause_press_mode", w_mode, exp_mode);
      w_pause = 1'b0;
      duty_q.push_back(1);
      wait_q_empty("pause_release", 16 + 40);

      // Asynchronous reset mid-ramp in chase mode.
      while (exp_mode != 2) press();
      wait_duty(5);
      chk("pre_reset_mode", w_mode, 2);
      #2;
      w_rst = 1'b1;
      #1;
      check_reset_outputs();
      exp_mode = 0;
      step();
      w_rst = 1'b0;
      measure_first_pd();

      chk("mode_queue_drained", mode_q.size(), 0);
      chk("duty_queue_drained", duty_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuai_led_breath_ctrl.md
Name: neuai_led_breath_ctrl

Overview:
Mode-sequencing controller for the board's four LEDs. It generates a shared breathing duty ramp and its PWM compare, then routes the result to the LEDs according to a mode selected by a debounced key press. The block runs in a single clock domain and needs no external clock dividers. It replaces the per-demo counter fabric as the reusable LED driver for future demos.

Parameters:
TICK_DIV, 50, clock cycles per PWM tick (1 us at 50 MHz)
PWM_STEPS, 1000, PWM ticks per PWM period; duty range 0..PWM_STEPS-1
CNT_W, 10, width of PWM counter and duty; requires PWM_STEPS <= 2^CNT_W
DEBOUNCE_CYCLES, 1000000, clocks the key must be stable (20 ms at 50 MHz)

Ports:
w_clk  in  1  system clock
w_rst  in  1  asynchronous reset, active-high
w_key_mode  in  1  raw mode key, active-low (pressed = 0), asynchronous to w_clk
w_pause  in  1  level; 1 freezes the duty ramp
w_led  out  4  LED drives, active-low (1 = off)
w_mode  out  2  current mode
w_duty  out  CNT_W  current linear duty
w_period_done  out  1  one-cycle pulse at the end of each PWM period

Behaviour:
- Reset (async, w_rst=1), applied at any time including mid-ramp:
  - Outputs: w_led=4'b1111, w_mode=0, w_duty=0, w_period_done=0.
  - Internal: prescaler=0, pwm_cnt=0, dir=up, active LED index=0, debounced key=1.
- Prescaler counts 0..TICK_DIV-1 and wraps. The tick pulse is asserted in the cycle where the prescaler equals TICK_DIV-1.
- pwm_cnt advances on each tick and wraps at PWM_STEPS-1 to 0. w_period_done=1 for exactly the cycle in which the tick and pwm_cnt==PWM_STEPS-1 coincide.
- Duty ramp updates on w_period_done, and only when w_pause=0:
  - Going up: duty<PWM_STEPS-1 gives duty+1. At the maximum, dir becomes down and duty becomes PWM_STEPS-2.
  - Going down: duty>0 gives duty-1. At 0, dir becomes up, duty becomes 1, and a cycle_done event fires.
  - Full breath cycle is 2*(PWM_STEPS-1) periods.
- Compare: on = (pwm_cnt < cmp), where cmp=duty. The complement compare value is PWM_STEPS-1-duty.
- w_led is registered, so it lags pwm_cnt by 1 clock. Duty 0 never lights the LED.
- Modes (w_mode):
  - 0 OFF: w_led=1111.
  - 1 ALL: all four LEDs follow on.
  - 2 CHASE: only LED[active] follows on; the others stay 1. Each cycle_done advances active 0→1→2→3→0.
  - 3 ALT: LED0 and LED2 use duty; LED1 and LED3 use the complement compare.
- Key input: 2-flop synchronizer, then a debounce counter. The debounced state changes only after DEBOUNCE_CYCLES consecutive equal samples. A press is a debounced 1→0 transition and produces a one-cycle press pulse.
- On a press pulse:
  - mode advances 0→1→2→3→0 on the next clock.
  - duty=0, dir=up, active=0.
  - prescaler and pwm_cnt continue running.
- Priority: a press pulse beats w_period_done in the same cycle. A press is honoured while w_pause=1 (mode advances and duty is cleared; the ramp stays frozen). A held key produces only one press.
- While w_pause=1, pwm_cnt keeps running, so the LEDs hold their current brightness.

Optional Feature:
LED_GAMMA_EN
- Defined: cmp = (duty*duty) >> CNT_W, using a 2*CNT_W-bit product. Example: duty 999 gives cmp 974; duty 500 gives cmp 244. Applies to both the direct and the complement compare paths. w_duty still reports the linear duty.
- Undefined: cmp = duty (linear).

Decomposition:
- Package neuai_led_pkg holds:
  - Mode codes MODE_OFF=2'd0, MODE_ALL=2'd1, MODE_CHASE=2'd2, MODE_ALT=2'd3.
  - LED_OFF=4'b1111.
  - Default TICK_DIV, PWM_STEPS and DEBOUNCE_CYCLES constants.
- One sub-module, neuai_key_debounce (synchronizer, debounce counter, press pulse), reusable for other keys.

Test Plan:
All scenarios use TICK_DIV=2, PWM_STEPS=8, CNT_W=3, DEBOUNCE_CYCLES=4, so one PWM period is 16 clocks.
1. Assert w_rst mid-ramp in mode 2 at duty=5 → same cycle w_led=1111, w_mode=0, w_duty=0; after release, w_period_done first pulses 16 clocks later.
2. Key low for 3 clocks, then high → no mode change. Key low for 10 clocks → w_mode 0→1 exactly once, w_duty=0.
3. Mode 1 → w_duty sequence per period is 0,1,...,7,6,...,0,1. At duty=3, each w_led bit is 0 for 6 of 16 clocks, lagging pwm_cnt by 1.
4. Mode 2 → LED0 only breathes. After 14 periods (duty returns to 0), LED1 takes over and LED0 stays 1. After 4 full cycles the active LED is back to LED0.
5. Mode 3 at duty=5 → LED0 and LED2 low for 10 clocks per period; LED1 and LED3 low for 4 clocks.
6. w_pause=1 at duty=4 for 5 periods → w_duty holds 4, w_period_done still pulses. A press during the pause → mode advances and duty=0; on release, duty advances to 1 at the next period end.
